mfc_top: RTL and testbench

- Multi-function digital clock top level: time-of-day clock, alarm, and stopwatch.
- Driven by one board clock, a bank of slide switches (SPDT) and five push buttons.
- Presents six BCD digits (HH:MM:SS) for the selected mode, plus alarm and mode status.
- Feeds the board display driver; contains its own 1 Hz prescaler, button debouncers and edge detectors.

---
 rtl/mfc_top.sv | 182 ++++++++++++++++++
 tb/tb_mfc_top.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mfc_top.sv
// Multi-function digital clock: time-of-day, alarm and stopwatch, with 1 Hz prescaler,
// per-button debounce/press detection and a six-digit BCD display mux.
module mfc_top #(
  parameter int CLK_PER_SEC = 100000000,
  parameter int DEB_CYCLES  = 1000000
) (
  input  logic        MCLK,
  input  logic [14:0] SPDT,
  input  logic [4:0]  button,
  output logic [23:0] disp_bcd,
  output logic [1:0]  cursor,
  output logic [1:0]  mode,
  output logic        alarm_out
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] M_CLK  = 2'd0;
  localparam logic [1:0] M_SW   = 2'd1;
  localparam logic [1:0] M_ASET = 2'd2;
  localparam logic [1:0] M_CSET = 2'd3;

  localparam int B_UP = 0, B_DN = 1, B_LEFT = 2, B_RIGHT = 3, B_START = 4;

  logic          rst_n;
  logic          unused_sw;
  logic [PW-1:0] pre;
  logic          tick;
  logic [DW-1:0] deb_cnt [5];
  logic [4:0]    deb_lvl;
  logic [4:0]    press;
  logic [17:0]   tod, alm, sw, tod_next, shown;
  logic          sw_run;
  logic [1:0]    mode_q;
  logic [5:0]    ring_ticks;
  logic          set_mode, set_entry, edit_ok;

  assign rst_n     = SPDT[0];
  assign unused_sw = ^SPDT[11:2];

  // {hour, min, sec}, 6 bits per field; one-second advance with full carry chain.
  function automatic logic [17:0] hms_tick(input logic [17:0] v);
    logic [5:0] s, m, h;
    s = v[5:0];
    m = v[11:6];
    h = v[17:12];
    if (s == 6'd59) begin
      s = 6'd0;
      if (m == 6'd59) begin
        m = 6'd0;
        h = (h == 6'd23) ? 6'd0 : h + 6'd1;
      end else begin
        m = m + 6'd1;
      end
    end else begin
      s = s + 6'd1;
    end
    return {h, m, s};
  endfunction

  // Single-field edit with wrap and no carry; up and down together cancel.
  function automatic logic [17:0] hms_edit(input logic [17:0] v, input logic [1:0] sel,
                                           input logic up, input logic dn);
    logic [17:0] r;
    logic [5:0]  f, top;
    r = v;
    case (sel)
      2'd1:    f = v[11:6];
      2'd2:    f = v[17:12];
      default: f = v[5:0];
    endcase
    top = (sel == 2'd2) ? 6'd23 : 6'd59;
    if (up && !dn)      f = (f == top) ? 6'd0 : f + 6'd1;
    else if (dn && !up) f = (f == 6'd0) ? top : f - 6'd1;
    case (sel)
      2'd1:    r[11:6]  = f;
      2'd2:    r[17:12] = f;
      default: r[5:0]   = f;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] f);
    return {4'(f / 6'd10), 4'(f % 6'd10)};
  endfunction

  always_comb begin
    mode = M_CLK;
    if (!rst_n)        mode = M_CLK;
    else if (SPDT[14]) mode = M_CSET;
    else if (SPDT[13]) mode = M_ASET;
    else if (SPDT[12]) mode = M_SW;
  end

  assign tick      = (pre == PRE_MAX) && (mode != M_CSET);
  assign tod_next  = hms_tick(tod);
  assign set_mode  = mode[1];
  // The first cycle in a set mode only re-homes the cursor; edits start the cycle after.
  assign set_entry = set_mode && (mode != mode_q);
  assign edit_ok   = set_mode && (mode == mode_q);

  always_comb begin
    case (mode)
      M_SW:    shown = sw;
      M_ASET:  shown = alm;
      default: shown = tod;
    endcase
    disp_bcd = {to_bcd(shown[17:12]), to_bcd(shown[11:6]), to_bcd(shown[5:0])};
  end

  // Accepted level moves after DEB_CYCLES consecutive differing samples; rise emits press.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
      deb_lvl <= '0;
      press   <= '0;
    end else begin
      press <= '0;
      for (int i = 0; i < 5; i++) begin
        if (button[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb_cnt[i] <= '0;
          deb_lvl[i] <= button[i];
          press[i]   <= button[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      tod        <= '0;
      alm        <= '0;
      sw         <= '0;
      sw_run     <= 1'b0;
      cursor     <= 2'd0;
      mode_q     <= M_CLK;
      alarm_out  <= 1'b0;
      ring_ticks <= '0;
    end else begin
      mode_q <= mode;
      if (mode == M_CSET || pre == PRE_MAX) pre <= '0;
      else                                  pre <= pre + 1'b1;

      if (edit_ok && mode == M_CSET) tod <= hms_edit(tod, cursor, press[B_UP], press[B_DN]);
      else if (tick)                 tod <= tod_next;

      if (edit_ok && mode == M_ASET) alm <= hms_edit(alm, cursor, press[B_UP], press[B_DN]);

      if (set_entry) begin
        cursor <= 2'd0;
      end else if (edit_ok) begin
        if (press[B_LEFT])       cursor <= (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
        else if (press[B_RIGHT]) cursor <= (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
      end

      if (mode == M_SW && press[B_START]) sw_run <= !sw_run;
      if (mode == M_SW && press[B_LEFT] && !sw_run) sw <= '0;
      else if (sw_run && tick)                      sw <= hms_tick(sw);

      // Match is judged on the value the time is about to take at this tick.
      if (!SPDT[1] || (|press)) begin
        alarm_out  <= 1'b0;
        ring_ticks <= '0;
      end else if (tick && tod_next == alm) begin
        alarm_out  <= 1'b1;
        ring_ticks <= '0;
      end else if (alarm_out && tick) begin
        if (ring_ticks == 6'd59) alarm_out <= 1'b0;
        ring_ticks <= ring_ticks + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_mfc_top.sv
// Directed bench for mfc_top: clock counting, debounce, set modes, stopwatch, alarm, reset.
module tb_mfc_top;

  localparam int CPS = 100;
  localparam int DEB = 4;

  logic        MCLK = 1'b0;
  logic [14:0] SPDT = 15'd0;
  logic [4:0]  button = 5'd0;
  logic [23:0] disp_bcd;
  logic [1:0]  cursor;
  logic [1:0]  mode;
  logic        alarm_out;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int unsigned cyc0;

  mfc_top #(.CLK_PER_SEC(CPS), .DEB_CYCLES(DEB)) dut (
    .MCLK(MCLK), .SPDT(SPDT), .button(button),
    .disp_bcd(disp_bcd), .cursor(cursor), .mode(mode), .alarm_out(alarm_out)
  );

  // clock/reset block
  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic press(input int idx);
    button[idx] = 1'b1;
    repeat (DEB + 3) @(negedge MCLK);
    button[idx] = 1'b0;
    repeat (DEB + 3) @(negedge MCLK);
  endtask

  task automatic press_n(input int idx, input int n);
    for (int k = 0; k < n; k++) press(idx);
  endtask

  task automatic press_both(input int a, input int b);
    button[a] = 1'b1;
    button[b] = 1'b1;
    repeat (DEB + 3) @(negedge MCLK);
    button[a] = 1'b0;
    button[b] = 1'b0;
    repeat (DEB + 3) @(negedge MCLK);
  endtask

  // One cycle in clock-set parks the prescaler at 0; the next tick lands 100 edges later.
  task automatic sync_pre();
    SPDT[14] = 1'b1;
    @(negedge MCLK);
    SPDT[14] = 1'b0;
  endtask

  initial begin
    repeat (10) @(negedge MCLK);
    chk("rst_disp", disp_bcd, 24'h000000);
    chk("rst_mode", mode, 24'd0);
    chk("rst_alarm", alarm_out, 24'd0);
    chk("rst_cursor", cursor, 24'd0);
    SPDT[0] = 1'b1;
    repeat (5 * CPS) @(posedge MCLK);
    @(negedge MCLK);
    chk("run_5s", disp_bcd, 24'h000005);
    chk("run_mode", mode, 24'd0);
    chk("run_alarm", alarm_out, 24'd0);

    // bounced up button in clock-set: one pulse only, time frozen
    SPDT[14] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      button[0] = ~button[0];
      @(negedge MCLK);
    end
    button[0] = 1'b1;
    repeat (10) @(negedge MCLK);
    button[0] = 1'b0;
    repeat (10) @(negedge MCLK);
    chk("cset_mode", mode, 24'd3);
    chk("bounce_up", disp_bcd, 24'h000006);
    repeat (300) @(negedge MCLK);
    chk("cset_frozen", disp_bcd, 24'h000006);

    press(3);
    chk("right_wrap", cursor, 24'd2);
    press(1);
    chk("hour_dn_wrap", disp_bcd, 24'h230006);
    press(2);
    chk("left_wrap", cursor, 24'd0);
    SPDT[14] = 1'b0;
    #1;
    chk("leave_mode", mode, 24'd0);
    chk("leave_disp", disp_bcd, 24'h230006);
    repeat (CPS) @(posedge MCLK);
    @(negedge MCLK);
    chk("resume", disp_bcd, 24'h230007);

    // build 23:59:59 and roll over
    SPDT[14] = 1'b1;
    press(2);
    chk("left_inc", cursor, 24'd1);
    press(1);
    press(3);
    press_n(1, 8);
    chk("set_235959", disp_bcd, 24'h235959);
    SPDT[14] = 1'b0;
    repeat (CPS - 1) @(posedge MCLK);
    @(negedge MCLK);
    chk("pre_wrap", disp_bcd, 24'h235959);
    @(posedge MCLK);
    @(negedge MCLK);
    chk("day_wrap", disp_bcd, 24'h000000);
    cyc0 = cyc;

    // alarm-set to 00:00:10; time keeps running meanwhile
    SPDT[13] = 1'b1;
    #1;
    chk("aset_mode", mode, 24'd2);
    chk("aset_disp", disp_bcd, 24'h000000);
    press(2);
    chk("aset_cursor", cursor, 24'd1);
    SPDT[13] = 1'b0;
    @(negedge MCLK);
    SPDT[13] = 1'b1;
    @(negedge MCLK);
    chk("reentry_cursor", cursor, 24'd0);
    press_n(0, 10);
    chk("alarm_10", disp_bcd, 24'h000010);
    press_both(0, 1);
    chk("up_dn_cancel", disp_bcd, 24'h000010);
    while (cyc < cyc0 + 450) @(negedge MCLK);

    SPDT[13] = 1'b0;
    SPDT[14] = 1'b1;
    @(negedge MCLK);
    chk("time_in_aset", disp_bcd, 24'h000004);
    press_n(0, 4);
    chk("time_08", disp_bcd, 24'h000008);
    SPDT[1] = 1'b1;
    SPDT[14] = 1'b0;
    repeat (2 * CPS - 1) @(posedge MCLK);
    @(negedge MCLK);
    chk("pre_alarm_t", disp_bcd, 24'h000009);
    chk("pre_alarm", alarm_out, 24'd0);
    @(posedge MCLK);
    @(negedge MCLK);
    chk("alarm_t", disp_bcd, 24'h000010);
    chk("alarm_ring", alarm_out, 24'd1);
    press(0);
    chk("alarm_clr", alarm_out, 24'd0);
    chk("up_ignored", disp_bcd, 24'h000010);

    SPDT[14] = 1'b1;
    press_n(1, 2);
    chk("time_08b", disp_bcd, 24'h000008);
    SPDT[1] = 1'b0;
    SPDT[14] = 1'b0;
    repeat (2 * CPS) @(posedge MCLK);
    @(negedge MCLK);
    chk("dis_alarm_t", disp_bcd, 24'h000010);
    chk("dis_alarm", alarm_out, 24'd0);

    // stopwatch
    SPDT[12] = 1'b1;
    #1;
    chk("sw_mode", mode, 24'd1);
    chk("sw_init", disp_bcd, 24'h000000);
    sync_pre();
    press(4);
    repeat (186) @(negedge MCLK);
    press(4);
    chk("sw_2s", disp_bcd, 24'h000002);
    repeat (150) @(negedge MCLK);
    chk("sw_frozen", disp_bcd, 24'h000002);
    press(2);
    chk("sw_clear", disp_bcd, 24'h000000);
    sync_pre();
    press(4);
    repeat (186) @(negedge MCLK);
    press(2);
    chk("sw_no_clear", disp_bcd, 24'h000002);
    SPDT[12] = 1'b0;
    repeat (100) @(negedge MCLK);
    SPDT[12] = 1'b1;
    #1;
    chk("sw_background", disp_bcd, 24'h000003);

    // asynchronous reset mid-count
    repeat (20) @(negedge MCLK);
    #2;
    SPDT[0] = 1'b0;
    #1;
    chk("async_disp", disp_bcd, 24'h000000);
    chk("async_mode", mode, 24'd0);
    chk("async_alarm", alarm_out, 24'd0);
    chk("async_cursor", cursor, 24'd0);
    @(negedge MCLK);
    SPDT[0] = 1'b1;
    repeat (250) @(negedge MCLK);
    chk("sw_stopped_mode", mode, 24'd1);
    chk("sw_stopped", disp_bcd, 24'h000000);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
